// File: rtl/serial_receiver_pkg.sv
// rtl/serial_receiver_pkg.sv - shared state encoding, bit-count width and field layout for serial_receiver
package serial_receiver_pkg;

    // Receiver FSM states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DATA      = 2'd1;
    localparam logic [1:0] ST_ACK       = 2'd2;
    localparam logic [1:0] ST_WAIT_STOP = 2'd3;

    // Bit counter: 3 bits plus a separate done flag set on the 8th bit
    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] bit_cnt_t;

    // Field positions within the first seven received bits (b1 at bit 6)
    localparam int RATE_MSB = 6;
    localparam int RATE_LSB = 4;
    localparam int PR_MSB   = 3;
    localparam int PR_LSB   = 0;

    typedef struct packed {
        logic [2:0] rate;
        logic [3:0] pr;
    } fields_t;

    // Split b1..b7 into the rate and pulse-rate fields; b8 never reaches here
    function automatic fields_t extract_fields(input logic [6:0] b);
        fields_t f;
        f.rate = b[RATE_MSB:RATE_LSB];
        f.pr   = b[PR_MSB:PR_LSB];
        return f;
    endfunction

endpackage

// File: rtl/sr_sync_edge.sv
// rtl/sr_sync_edge.sv - two-flop synchronizer with rise/fall detection
module sr_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronize the async line and keep the previous synchronized value; reset to idle-bus high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - two-wire serial byte receiver extracting Rate and PR fields with ACK
module serial_receiver
    import serial_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       SDA_Enable,
    output logic [3:0] PR,
    output logic [2:0] Rate
);

    logic       scl_level;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_level;
    logic       sda_rise;
    logic       sda_fall;
    logic       scl_edge;
    logic       start_det;
    logic       stop_det;

    logic [1:0] state;
    bit_cnt_t   bit_cnt;
    logic       bit_done;
    logic [7:0] shift;
    logic       ack_clk;
    fields_t    fields;

    sr_sync_edge u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SCL),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    sr_sync_edge u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SDA),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // An SCL edge in the same sample masks any START/STOP interpretation of an SDA edge
    assign scl_edge  = scl_rise | scl_fall;
    assign start_det = sda_fall & scl_level & ~scl_edge;
    assign stop_det  = sda_rise & scl_level & ~scl_edge;

    // Receiver FSM: START always (re)starts a byte, STOP always returns to idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_done <= 1'b0;
            shift    <= '0;
            ack_clk  <= 1'b0;
            fields   <= '0;
        end else if (start_det) begin
            state    <= ST_DATA;
            bit_cnt  <= '0;
            bit_done <= 1'b0;
            shift    <= '0;
            ack_clk  <= 1'b0;
        end else if (stop_det) begin
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_DATA: begin
                    if (scl_rise && !bit_done) begin
                        shift               <= {shift[6:0], sda_level};
                        {bit_done, bit_cnt} <= {1'b0, bit_cnt} + 4'd1;
                    end else if (scl_fall && bit_done) begin
                        state   <= ST_ACK;
                        ack_clk <= 1'b0;
                        fields  <= extract_fields(shift[7:1]);
                    end
                end
                ST_ACK: begin
                    if (scl_rise) begin
                        ack_clk <= 1'b1;
                    end else if (scl_fall && ack_clk) begin
                        state <= ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    state <= ST_WAIT_STOP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Open-drain ACK: only ever pull low, otherwise release
    assign SDA  = ((state == ST_ACK) && SDA_Enable) ? 1'b0 : 1'bz;

    assign Rate = fields.rate;
    assign PR   = fields.pr;

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed scoreboard testbench for serial_receiver
module tb_serial_receiver;
    import serial_receiver_pkg::*;

    typedef struct packed {
        logic [2:0] rate;
        logic [3:0] pr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       SCL;
    logic       SDA_Enable;
    logic       sda_low;
    logic [3:0] PR;
    logic [2:0] Rate;
    wire        SDA;

    int   n_assert;
    int   n_fail;
    exp_t sb_q[$];
    exp_t last_exp;

    pullup (SDA);
    assign SDA = sda_low ? 1'b0 : 1'bz;

    serial_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .SCL        (SCL),
        .SDA        (SDA),
        .SDA_Enable (SDA_Enable),
        .PR         (PR),
        .Rate       (Rate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        wait_clk(5);
        sda_low = 1'b1;
        wait_clk(5);
        SCL = 1'b0;
        wait_clk(3);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        wait_clk(3);
        SCL = 1'b1;
        wait_clk(5);
        sda_low = 1'b0;
        wait_clk(5);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b;
        wait_clk(3);
        SCL = 1'b1;
        wait_clk(5);
        SCL = 1'b0;
        wait_clk(2);
    endtask

    // Send a full byte MSB first and record the fields the receiver should report
    task automatic send_byte(input logic [7:0] b);
        exp_t e;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        e.rate   = {b[7], b[6], b[5]};
        e.pr     = {b[4], b[3], b[2], b[1]};
        sb_q.push_back(e);
        last_exp = e;
    endtask

    task automatic ack_clock(input logic en);
        sda_low    = 1'b0;
        SDA_Enable = en;
        wait_clk(3);
        SCL = 1'b1;
        wait_clk(2);
        check(en ? "ack_sda_driven" : "ack_sda_released", {7'd0, SDA}, en ? 8'd0 : 8'd1);
        wait_clk(3);
        SCL = 1'b0;
        wait_clk(5);
        check("sda_released_after_ack", {7'd0, SDA}, 8'd1);
        SDA_Enable = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        n_assert++;
        assert (sb_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_rate"}, {5'd0, Rate}, {5'd0, e.rate});
            check({tag, "_pr"}, {4'd0, PR}, {4'd0, e.pr});
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        SCL        = 1'b1;
        sda_low    = 1'b0;
        SDA_Enable = 1'b0;
        last_exp   = '0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(3);

        check("reset_rate", {5'd0, Rate}, 8'd0);
        check("reset_pr", {4'd0, PR}, 8'd0);
        check("reset_sda", {7'd0, SDA}, 8'd1);

        bus_start();
        send_byte(8'b1111_1110);
        ack_clock(1'b1);
        bus_stop();
        compare_outputs("byte_fe");

        bus_start();
        send_byte(8'b0101_0101);
        ack_clock(1'b1);
        bus_stop();
        compare_outputs("byte_55");

        bus_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        sb_q.push_back(last_exp);
        bus_stop();
        compare_outputs("partial_byte");
        check("partial_state_idle", {6'd0, dut.state}, {6'd0, ST_IDLE});

        bus_start();
        send_byte(8'b1011_0011);
        ack_clock(1'b0);
        bus_stop();
        compare_outputs("byte_b3_noack");

        bus_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        last_exp = '0;
        sb_q.push_back(last_exp);
        wait_clk(2);
        compare_outputs("mid_byte_reset");
        check("reset_state_idle", {6'd0, dut.state}, {6'd0, ST_IDLE});
        sda_low = 1'b0;
        wait_clk(3);
        SCL = 1'b1;
        wait_clk(5);

        bus_start();
        send_byte(8'b0011_1100);
        ack_clock(1'b1);
        bus_stop();
        compare_outputs("byte_3c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  input  1  single system clock, rising edge; all state updates on this edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 SCL  input  1  serial clock from bus master, asynchronous to clk.
REQ-005 SDA  inout  1  serial data; DUT drives only 0 (ACK) or Z, never 1.
REQ-006 SDA_Enable  input  1  master has released SDA (1 = DUT may drive ACK).
REQ-007 PR  output  4  registered pulse-rate field from last valid byte.
REQ-008 Rate  output  3  registered rate field from last valid byte.

Function
REQ-009 SHALL sample SCL and SDA on clk via a 2-flop synchronizer each, then a previous-value register for edge detection.
REQ-010 Legal bus timing: SCL high and low phases each >=3 clk periods; SDA changes only while SCL low, except START/STOP.
REQ-011 START: synchronized SDA falling while synchronized SCL high.
REQ-012 STOP: synchronized SDA rising while synchronized SCL high.
REQ-013 States: IDLE, DATA, ACK, WAIT_STOP.
REQ-014 IDLE -> DATA on START; bit counter cleared to 0, shift register cleared.
REQ-015 DATA: each SCL rising edge shifts synchronized SDA into an 8-bit shift register, MSB first; counter increments.
REQ-016 DATA -> ACK on the SCL falling edge following the 8th rising edge.
REQ-017 ACK: SDA driven 0 while state==ACK and SDA_Enable==1; otherwise Z.
REQ-018 ACK -> WAIT_STOP on the next SCL falling edge after one SCL rising edge (ACK clock); SDA released on entering WAIT_STOP.
REQ-019 Field mapping of byte b1..b8 (b1 first received): Rate = b1b2b3, PR = b4b5b6b7, b8 ignored.
REQ-020 Rate and PR SHALL update in the clk cycle DATA -> ACK occurs (1 cycle after the detected 8th-bit edge); otherwise hold.
REQ-021 WAIT_STOP -> IDLE on STOP; WAIT_STOP -> DATA on repeated START.
REQ-022 STOP detected in DATA or ACK: return to IDLE; outputs not updated if the byte is incomplete.
REQ-023 START detected in DATA or ACK (repeated start): restart reception at bit 0, discard partial byte.
REQ-024 Always ACKs; no address match, no NACK generation.
REQ-025 Simultaneous SCL and SDA change in one sampled cycle: SCL edge has priority; no START/STOP recognized that cycle.

Reset
REQ-026 reset=1 asynchronously forces: state IDLE, counter 0, shift register 0, Rate=3'b000, PR=4'b0000, SDA released (Z), synchronizers to 1 (idle bus).
REQ-027 Reset mid-byte discards the byte; reception resumes only after a new START.

Structure
REQ-028 State encoding, bit-count width (3 bits + done) and field positions belong in a shared package.
REQ-029 One natural sub-module: sr_sync_edge (2-flop synchronizer plus rise/fall detect), instantiated for SCL and SDA.

Verification
REQ-030 Reset asserted then released -> Rate=000, PR=0000, SDA=Z.
REQ-031 START, byte 1111_1110, ACK, STOP -> Rate=111, PR=1111; SDA=0 during ACK while SDA_Enable=1.
REQ-032 START, byte 0101_0101, ACK, STOP -> Rate=010, PR=1010.
REQ-033 START, 4 bits, STOP -> outputs retain previous values (010/1010), state IDLE.
REQ-034 START, byte 1011_0011, SDA_Enable=0 during ACK clock -> SDA stays Z; Rate=101, PR=1001.
REQ-035 reset pulse after 5 bits, then full byte 0011_1100 -> Rate=001, PR=1110.
